seq_detect_prog: RTL and testbench

Programmable serial bit-sequence detector with a registered (Moore-style) match output. It is the parametrised successor to the team's fixed-pattern detectors. The pattern, its length and the overlap mode are loaded at run time, so one instance covers any pattern up to `PAT_W` bits. It sits on a single-bit serial input stream with a qualifier and feeds a match pulse and an optional saturating match counter to downstream control logic.

---
 rtl/seq_detect_prog.sv | 129 ++++++++++++
 tb/tb_seq_detect_prog.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/seq_detect_prog.sv
// seq_detect_prog: programmable serial bit-sequence detector with a registered match pulse.
// Optional saturating match counter is enabled by defining SEQ_DETECT_CNT_EN.
`default_nettype none

module seq_detect_prog #(
    parameter int PAT_W = 8,
    parameter int LEN_W = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_load,
    input  logic [PAT_W-1:0] cfg_pat,
    input  logic [LEN_W-1:0] cfg_len,
    input  logic             cfg_ovl,
    input  logic             x,
    input  logic             x_valid,
    output logic             z,
    output logic             armed,
    output logic             cfg_err,
    output logic [CNT_W-1:0] match_cnt
);

    localparam logic [LEN_W-1:0] c_LEN_MAX = LEN_W'(PAT_W);

    typedef enum logic [0:0] {
        ST_UNCFG = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [PAT_W-1:0] r_pat;
    logic [LEN_W-1:0] r_len;
    logic             r_ovl;
    logic [PAT_W-1:0] r_hist;
    logic [LEN_W-1:0] r_fill;
    logic             r_z;
    logic             r_cfg_err;

    logic             w_cfg_ok;
    logic             w_accept;
    logic [PAT_W-1:0] w_hist_nxt;
    logic [LEN_W-1:0] w_fill_inc;
    logic [PAT_W-1:0] w_mask;
    logic             w_match;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_UNCFG;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // A configuration load takes priority over any bit presented in the same cycle.
    always_comb begin
        w_state_nxt = r_state;
        w_cfg_ok    = (cfg_len != '0) && (cfg_len <= c_LEN_MAX);
        w_accept    = 1'b0;
        w_hist_nxt  = {r_hist[PAT_W-2:0], x};
        w_fill_inc  = (r_fill >= c_LEN_MAX) ? r_fill : r_fill + LEN_W'(1);
        w_mask      = '0;
        w_match     = 1'b0;

        if (cfg_load) begin
            w_state_nxt = w_cfg_ok ? ST_RUN : ST_UNCFG;
        end

        for (int i = 0; i < PAT_W; i++) begin
            w_mask[i] = (i < int'(r_len));
        end

        w_accept = (r_state == ST_RUN) && x_valid && !cfg_load;
        w_match  = w_accept && (w_fill_inc >= r_len)
                   && (((w_hist_nxt ^ r_pat) & w_mask) == '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pat     <= '0;
            r_len     <= '0;
            r_ovl     <= 1'b0;
            r_hist    <= '0;
            r_fill    <= '0;
            r_z       <= 1'b0;
            r_cfg_err <= 1'b0;
        end else if (cfg_load) begin
            r_pat     <= cfg_pat;
            r_len     <= cfg_len;
            r_ovl     <= cfg_ovl;
            r_hist    <= '0;
            r_fill    <= '0;
            r_z       <= 1'b0;
            r_cfg_err <= !w_cfg_ok;
        end else begin
            r_z <= w_match;
            if (w_accept) begin
                r_hist <= w_hist_nxt;
                // Non-overlap mode restarts the fill so the next match needs fresh bits.
                r_fill <= (w_match && !r_ovl) ? '0 : w_fill_inc;
            end
        end
    end

    assign z       = r_z;
    assign armed   = (r_state == ST_RUN);
    assign cfg_err = r_cfg_err;

`ifdef SEQ_DETECT_CNT_EN
    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst || cfg_load) begin
            r_cnt <= '0;
        end else if (r_z && (r_cnt != '1)) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign match_cnt = r_cnt;
`else
    assign match_cnt = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_seq_detect_prog.sv
// tb_seq_detect_prog: scoreboard bench for seq_detect_prog (PAT_W=8, LEN_W=4, CNT_W=2).
`default_nettype none

module tb_seq_detect_prog;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       cfg_load = 1'b0;
    logic [7:0] cfg_pat = '0;
    logic [3:0] cfg_len = '0;
    logic       cfg_ovl = 1'b0;
    logic       x = 1'b0;
    logic       x_valid = 1'b0;
    logic       z;
    logic       armed;
    logic       cfg_err;
    logic [1:0] match_cnt;

    seq_detect_prog #(.PAT_W(8), .LEN_W(4), .CNT_W(2)) dut (
        .clk(clk), .rst(rst), .cfg_load(cfg_load), .cfg_pat(cfg_pat),
        .cfg_len(cfg_len), .cfg_ovl(cfg_ovl), .x(x), .x_valid(x_valid),
        .z(z), .armed(armed), .cfg_err(cfg_err), .match_cnt(match_cnt)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: accepted bits kept oldest-first, capped at 8 entries.
    bit         m_armed, m_err, m_z, m_ovl;
    bit   [7:0] m_pat;
    int         m_len;
    int         m_cnt;
    bit         m_bits[$];

    logic [4:0] exp_q[$];
    string      tag_q[$];

    task automatic check_val(input string tag, input logic [4:0] got, input logic [4:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got {z,armed,err,cnt}=%b exp=%b", tag, got, exp);
        end
    endtask

    task automatic model_edge(input bit r, input bit ld, input bit [7:0] p, input int l,
                              input bit o, input bit v, input bit b);
        bit hit;
        if (r) begin
            m_armed = 0; m_err = 0; m_z = 0; m_cnt = 0; m_pat = 0; m_len = 0; m_ovl = 0;
            m_bits.delete();
        end else if (ld) begin
            m_pat = p; m_len = l; m_ovl = o;
            m_armed = (l >= 1 && l <= 8);
            m_err = !m_armed;
            m_z = 0; m_cnt = 0;
            m_bits.delete();
        end else begin
`ifdef SEQ_DETECT_CNT_EN
            if (m_z && m_cnt < 3) m_cnt++;
`endif
            hit = 0;
            if (m_armed && v) begin
                m_bits.push_back(b);
                if (m_bits.size() > 8) void'(m_bits.pop_front());
                if (m_bits.size() >= m_len) begin
                    hit = 1;
                    for (int i = 0; i < m_len; i++)
                        if (m_bits[m_bits.size() - 1 - i] != m_pat[i]) hit = 0;
                end
                if (hit && !m_ovl) m_bits.delete();
            end
            m_z = hit;
        end
    endtask

    task automatic step(input string tag, input bit r, input bit ld, input bit [7:0] p,
                        input int l, input bit o, input bit v, input bit b);
        logic [4:0] e;
        string      t;
        rst = r; cfg_load = ld; cfg_pat = p; cfg_len = 4'(l); cfg_ovl = o;
        x_valid = v; x = b;
        model_edge(r, ld, p, l, o, v, b);
        exp_q.push_back({m_z, m_armed, m_err, 2'(m_cnt)});
        tag_q.push_back(tag);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        check_val(t, {z, armed, cfg_err, match_cnt}, e);
    endtask

    task automatic do_rst(input string tag);
        step(tag, 1, 0, 8'h00, 0, 0, 0, 0);
    endtask
    task automatic do_cfg(input string tag, input bit [7:0] p, input int l, input bit o);
        step(tag, 0, 1, p, l, o, 0, 0);
    endtask
    task automatic do_bit(input string tag, input bit b);
        step(tag, 0, 0, 8'h00, 0, 0, 1, b);
    endtask
    task automatic do_idle(input string tag, input int n);
        for (int i = 0; i < n; i++) step(tag, 0, 0, 8'h00, 0, 0, 0, 0);
    endtask
    task automatic do_stream(input string tag, input int n, input bit [15:0] bits);
        for (int i = n - 1; i >= 0; i--) do_bit(tag, bits[i]);
    endtask

    initial begin
        do_rst("reset0");
        do_rst("reset1");
        do_idle("reset_idle", 2);

        do_cfg("cfg_1110_novl", 8'h0E, 4, 0);
        do_stream("s_1110x2", 8, 16'b1110_1110);
        do_idle("post_1110", 2);

        do_cfg("cfg_1011_ovl", 8'h0B, 4, 1);
        do_stream("s_1011_ovl", 7, 16'b1011011);
        do_idle("post_ovl", 2);
        do_cfg("cfg_1011_novl", 8'h0B, 4, 0);
        do_stream("s_1011_novl", 7, 16'b1011011);
        do_idle("post_novl", 2);

        do_cfg("cfg_110", 8'h06, 3, 0);
        do_bit("gap_b1", 1);
        do_idle("gap_i1", 1);
        do_bit("gap_b2", 1);
        do_idle("gap_i2", 2);
        do_bit("gap_b3", 0);
        do_idle("gap_post", 2);

        do_cfg("cfg_len0", 8'h0E, 0, 0);
        do_stream("s_len0", 8, 16'b1110_1110);
        do_cfg("cfg_len9", 8'h0E, 9, 1);
        do_stream("s_len9", 8, 16'b1110_1110);
        do_cfg("cfg_legal", 8'h0E, 4, 0);
        do_idle("legal_idle", 1);

        do_stream("rst_pre", 3, 16'b111);
        step("rst_mid", 1, 0, 8'h00, 0, 0, 1, 0);
        do_idle("rst_post", 1);
        do_cfg("cfg_after_rst", 8'h0E, 4, 0);
        do_bit("lone_0", 0);
        do_stream("s_after_rst", 4, 16'b1110);
        do_idle("after_rst_post", 2);

        do_cfg("cfg_sat", 8'h01, 1, 1);
        do_stream("s_sat", 6, 16'b111111);
        do_idle("sat_post", 3);

        step("cfg_and_bit", 0, 1, 8'h01, 1, 1, 1, 1);
        do_idle("cfg_and_bit_post", 2);
        do_stream("s_mix", 5, 16'b10110);
        do_idle("final", 2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
